// File: rtl/rmii_tx_arbiter.sv
// Two-requester round-robin arbiter that frames bytes (preamble, SFD, data) for an RMII serializer.
// Define TX_FCS_EN to append a CRC-32 FCS computed over the data bytes.
module rmii_tx_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0_req,
    input  logic       s1_req,
    input  logic [7:0] s0_data,
    input  logic [7:0] s1_data,
    input  logic       s0_valid,
    input  logic       s1_valid,
    input  logic       s0_last,
    input  logic       s1_last,
    output logic       s0_gnt,
    output logic       s1_gnt,
    output logic       s0_ack,
    output logic       s1_ack,
    output logic [7:0] phy_tx_data,
    output logic       phy_tx_valid,
    output logic       frame_done,
    output logic       underrun
);
    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSfd,
        StData,
`ifdef TX_FCS_EN
        StFcs,
`endif
        StIfg
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic       prio_q, prio_d;
    logic [7:0] phy_data_q, phy_data_d;
    logic       phy_valid_q, phy_valid_d;
    logic       done_q, done_d;
    logic       under_q, under_d;
    logic       pick;
    logic [7:0] in_data;
    logic       in_valid, in_last;

    // prio_q names the requester that wins a tie; a lone requester always wins.
    assign pick     = (s0_req & s1_req) ? prio_q : s1_req;
    assign in_data  = gnt_q[1] ? s1_data  : s0_data;
    assign in_valid = gnt_q[1] ? s1_valid : s0_valid;
    assign in_last  = gnt_q[1] ? s1_last  : s0_last;

`ifdef TX_FCS_EN
    logic [31:0] crc_q, crc_d, fcs;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign fcs = ~crc_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        prio_d      = prio_q;
        phy_data_d  = 8'h00;
        phy_valid_d = 1'b0;
        done_d      = 1'b0;
        under_d     = 1'b0;
`ifdef TX_FCS_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            StIdle: begin
                if (s0_req | s1_req) begin
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    prio_d  = ~pick;
                    cnt_d   = 4'd0;
                    state_d = StPre;
                end
            end
            StPre: begin
                phy_valid_d = 1'b1;
                phy_data_d  = 8'h55;
                if (cnt_q == 4'd6) begin
                    cnt_d   = 4'd0;
                    state_d = StSfd;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSfd: begin
                phy_valid_d = 1'b1;
                phy_data_d  = 8'hD5;
                state_d     = StData;
`ifdef TX_FCS_EN
                crc_d       = 32'hFFFF_FFFF;
`endif
            end
            StData: begin
                cnt_d = 4'd0;
                if (in_valid) begin
                    phy_valid_d = 1'b1;
                    phy_data_d  = in_data;
`ifdef TX_FCS_EN
                    crc_d       = crc_byte(crc_q, in_data);
`endif
                    if (in_last) begin
                        gnt_d = 2'b00;
`ifdef TX_FCS_EN
                        state_d = StFcs;
`else
                        done_d  = 1'b1;
                        state_d = StIfg;
`endif
                    end
                end else begin
                    // Starved mid-frame: abandon the frame without an FCS.
                    gnt_d   = 2'b00;
                    under_d = 1'b1;
                    state_d = StIfg;
                end
            end
`ifdef TX_FCS_EN
            StFcs: begin
                phy_valid_d = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    phy_data_d = fcs[7:0];
                    2'd1:    phy_data_d = fcs[15:8];
                    2'd2:    phy_data_d = fcs[23:16];
                    default: phy_data_d = fcs[31:24];
                endcase
                if (cnt_q == 4'd3) begin
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    state_d = StIfg;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            StIfg: begin
                if (cnt_q == 4'd11) begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            gnt_q       <= 2'b00;
            prio_q      <= 1'b0;
            phy_data_q  <= 8'h00;
            phy_valid_q <= 1'b0;
            done_q      <= 1'b0;
            under_q     <= 1'b0;
`ifdef TX_FCS_EN
            crc_q       <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            prio_q      <= prio_d;
            phy_data_q  <= phy_data_d;
            phy_valid_q <= phy_valid_d;
            done_q      <= done_d;
            under_q     <= under_d;
`ifdef TX_FCS_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign s0_gnt       = gnt_q[0];
    assign s1_gnt       = gnt_q[1];
    assign s0_ack       = gnt_q[0] & (state_q == StData);
    assign s1_ack       = gnt_q[1] & (state_q == StData);
    assign phy_tx_data  = phy_data_q;
    assign phy_tx_valid = phy_valid_q;
    assign frame_done   = done_q;
    assign underrun     = under_q;
endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// Self-checking bench for rmii_tx_arbiter: cycle table for a single frame, directed corner cases,
// and randomized frames checked against a transaction-level model.
module tb_rmii_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] req_v, valid_v, last_v;
    logic [7:0] data_v [2];
    logic       s0_gnt, s1_gnt, s0_ack, s1_ack, phy_tx_valid, frame_done, underrun;
    logic [7:0] phy_tx_data;
    logic [1:0] gnt_w, ack_w;
    assign gnt_w = {s1_gnt, s0_gnt};
    assign ack_w = {s1_ack, s0_ack};

    rmii_tx_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .s0_req(req_v[0]), .s1_req(req_v[1]),
        .s0_data(data_v[0]), .s1_data(data_v[1]),
        .s0_valid(valid_v[0]), .s1_valid(valid_v[1]),
        .s0_last(last_v[0]), .s1_last(last_v[1]),
        .s0_gnt(s0_gnt), .s1_gnt(s1_gnt), .s0_ack(s0_ack), .s1_ack(s1_ack),
        .phy_tx_data(phy_tx_data), .phy_tx_valid(phy_tx_valid),
        .frame_done(frame_done), .underrun(underrun)
    );

    typedef struct {
        logic [7:0] b [16];
        int         len;
        int         abort_at;
    } frame_t;

    typedef struct {
        int         cyc;
        logic       valid;
        logic [7:0] data;
        logic       gnt0;
        logic       ack0;
        logic       done;
    } row_t;

    frame_t fq [2][$];
    int     rd [2];
    int     idx [2];
    logic   drop_en = 1'b0;
    int     n_checks = 0;
    int     n_pass = 0;
    int     clr_gen = 0;
    int     m_prio = 0;

    logic [7:0] got_bytes [$];
    int got_len [$], got_owner [$], got_gap [$];
    int done_cnt, under_cnt, zero_viol, gnt_viol;
    logic [7:0] exp_bytes [$];
    int exp_len [$], exp_owner [$], exp_gap [$];
    int exp_done, exp_under;

`ifdef TX_FCS_EN
    localparam int FrameLen9 = 21;
`else
    localparam int FrameLen9 = 17;
`endif

    // Requester driver: offers bytes one step after each edge, advances on ack.
    initial begin
        frame_t f;
        req_v = '0; valid_v = '0; last_v = '0; data_v[0] = 8'h00; data_v[1] = 8'h00;
        rd[0] = 0; rd[1] = 0; idx[0] = 0; idx[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (!rst_n) begin
                    rd[n]  = fq[n].size();
                    idx[n] = 0;
                end
                if (rd[n] < fq[n].size()) begin
                    f = fq[n][rd[n]];
                    req_v[n]   = (drop_en && gnt_w[n]) ? ($urandom_range(0, 1) != 0) : 1'b1;
                    data_v[n]  = f.b[idx[n]];
                    valid_v[n] = (idx[n] != f.abort_at);
                    last_v[n]  = (idx[n] == f.len - 1);
                    if (ack_w[n]) begin
                        if (!valid_v[n] || last_v[n]) begin
                            rd[n]++;
                            idx[n] = 0;
                        end else begin
                            idx[n]++;
                        end
                    end
                end else begin
                    req_v[n] = 1'b0; valid_v[n] = 1'b0; last_v[n] = 1'b0; data_v[n] = 8'h00;
                end
            end
        end
    end

    // Output monitor: splits phy_tx_valid into bursts and measures the low gap before each.
    initial begin
        int seen = 0;
        logic in_burst = 1'b0, have_prev = 1'b0;
        int low_cnt = 0;
        done_cnt = 0; under_cnt = 0; zero_viol = 0; gnt_viol = 0;
        forever begin
            @(negedge clk);
            if (seen != clr_gen) begin
                seen = clr_gen;
                got_bytes.delete(); got_len.delete(); got_owner.delete(); got_gap.delete();
                in_burst = 1'b0; have_prev = 1'b0; low_cnt = 0;
                done_cnt = 0; under_cnt = 0; zero_viol = 0; gnt_viol = 0;
            end
            if (phy_tx_valid) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    got_len.push_back(0);
                    got_owner.push_back(s1_gnt ? 1 : 0);
                    got_gap.push_back(have_prev ? low_cnt : -1);
                end
                got_bytes.push_back(phy_tx_data);
                got_len[got_len.size()-1]++;
            end else begin
                if (in_burst) begin
                    in_burst = 1'b0; have_prev = 1'b1; low_cnt = 0;
                end
                low_cnt++;
                if (phy_tx_data != 8'h00) zero_viol++;
            end
            if (frame_done) done_cnt++;
            if (underrun) under_cnt++;
            if (s0_gnt && s1_gnt) gnt_viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic push(input int n, input int len, input int abort_at, input logic [127:0] v);
        frame_t f;
        for (int i = 0; i < 16; i++) f.b[i] = v[8*i +: 8];
        f.len = len;
        f.abort_at = abort_at;
        fq[n].push_back(f);
    endtask

    function automatic logic [31:0] ref_crc(input frame_t f);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic fb;
        for (int i = 0; i < f.len; i++)
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ f.b[i][j];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        return ~c;
    endfunction

    // Transaction model: every queued frame is pending at each IDLE; ties alternate.
    task automatic model_run(input int b0, input int b1);
        int p [2];
        int pick, n;
        logic prev_abort = 1'b0, first = 1'b1, aborted;
        logic [31:0] crc;
        frame_t f;
        p[0] = b0; p[1] = b1;
        exp_bytes.delete(); exp_len.delete(); exp_owner.delete(); exp_gap.delete();
        exp_done = 0; exp_under = 0;
        while (p[0] < fq[0].size() || p[1] < fq[1].size()) begin
            if (p[0] < fq[0].size() && p[1] < fq[1].size()) pick = m_prio;
            else pick = (p[1] < fq[1].size()) ? 1 : 0;
            m_prio = 1 - pick;
            f = fq[pick][p[pick]];
            p[pick]++;
            aborted = (f.abort_at >= 0 && f.abort_at < f.len);
            n = aborted ? f.abort_at : f.len;
            for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
            exp_bytes.push_back(8'hD5);
            for (int i = 0; i < n; i++) exp_bytes.push_back(f.b[i]);
            if (!aborted) begin
`ifdef TX_FCS_EN
                crc = ref_crc(f);
                for (int i = 0; i < 4; i++) exp_bytes.push_back(crc[8*i +: 8]);
                n += 4;
`else
                crc = 32'd0;
`endif
                exp_done++;
            end else begin
                exp_under++;
            end
            exp_len.push_back(8 + n);
            exp_owner.push_back(pick);
            exp_gap.push_back(first ? -1 : (prev_abort ? 14 : 13));
            first = 1'b0;
            prev_abort = aborted;
        end
    endtask

    task automatic begin_scn(output int b0, output int b1);
        clr_gen++;
        @(negedge clk);
        @(posedge clk);
        b0 = fq[0].size();
        b1 = fq[1].size();
    endtask

    task automatic run_and_check(input string name, input int b0, input int b1);
        int t = 0;
        logic pending;
        model_run(b0, b1);
        pending = 1'b1;
        while (pending && t < 5000) begin
            @(negedge clk);
            t++;
            pending = (rd[0] < fq[0].size()) || (rd[1] < fq[1].size());
        end
        chk({name, "_drain_timeout"}, pending, 1'b0);
        repeat (40) @(negedge clk);
        chk({name, "_bursts"}, got_len.size(), exp_len.size());
        for (int i = 0; i < got_len.size() && i < exp_len.size(); i++) begin
            chk({name, "_owner"}, got_owner[i], exp_owner[i]);
            chk({name, "_gap"}, got_gap[i], exp_gap[i]);
            chk({name, "_len"}, got_len[i], exp_len[i]);
        end
        chk({name, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            chk({name, "_byte"}, got_bytes[i], exp_bytes[i]);
        chk({name, "_frame_done"}, done_cnt, exp_done);
        chk({name, "_underrun"}, under_cnt, exp_under);
        chk({name, "_idle_data_zero"}, zero_viol, 0);
        chk({name, "_gnt_onehot"}, gnt_viol, 0);
    endtask

    initial begin
        row_t tab [10];
        int b0, b1, len, ab, who;
        logic [127:0] v;
        // Cycle 0 is the IDLE cycle that samples s0_req.
        tab[0] = '{0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tab[1] = '{1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tab[2] = '{2,  1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        tab[3] = '{8,  1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        tab[4] = '{9,  1'b1, 8'hD5, 1'b1, 1'b1, 1'b0};
        tab[5] = '{10, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0};
        tab[6] = '{11, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0};
        tab[7] = '{12, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
        tab[8] = '{13, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tab[9] = '{23, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        #12;
        chk("rst_phy_valid", phy_tx_valid, 1'b0);
        chk("rst_phy_data", phy_tx_data, 8'h00);
        chk("rst_gnt", gnt_w, 2'b00);
        chk("rst_ack", ack_w, 2'b00);
        chk("rst_done_underrun", {frame_done, underrun}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        m_prio = 0;

        // Both requesters busy from reset: s0, s1, s0, s1 with 13-cycle gaps.
        begin_scn(b0, b1);
        push(0, 2, -1, 128'h0201); push(0, 2, -1, 128'h0403);
        push(1, 2, -1, 128'h1211); push(1, 2, -1, 128'h1413);
        run_and_check("rr", b0, b1);

        // s0 starves on its third data byte; s1 is served next.
        begin_scn(b0, b1);
        push(0, 4, 2, 128'h44332211);
        push(1, 2, -1, 128'h6A5A);
        run_and_check("abort", b0, b1);

        // Cycle-exact single frame from s0.
        begin_scn(b0, b1);
        push(0, 3, -1, 128'hC3B2A1);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            for (int r = 0; r < 10; r++) begin
                if (tab[r].cyc == c) begin
                    chk($sformatf("tab%0d_valid", c), phy_tx_valid, tab[r].valid);
                    chk($sformatf("tab%0d_data", c), phy_tx_data, tab[r].data);
                    chk($sformatf("tab%0d_gnt0", c), s0_gnt, tab[r].gnt0);
                    chk($sformatf("tab%0d_ack0", c), s0_ack, tab[r].ack0);
                    chk($sformatf("tab%0d_done", c), frame_done, tab[r].done);
                    chk($sformatf("tab%0d_underrun", c), underrun, 1'b0);
                end
            end
        end
        repeat (20) @(negedge clk);
        chk("tab_done_count", done_cnt, 1);
        m_prio = 1;

        // s1 sends "123456789"; with FCS the trailer is 26 39 F4 CB.
        begin_scn(b0, b1);
        push(1, 9, -1, 128'h393837363534333231);
        run_and_check("crc", b0, b1);
        chk("crc_burst_len", (got_len.size() > 0) ? got_len[0] : 0, FrameLen9);
        if (got_bytes.size() >= FrameLen9) begin
            chk("last_data_byte", got_bytes[16], 8'h39);
`ifdef TX_FCS_EN
            chk("fcs_b0", got_bytes[17], 8'h26);
            chk("fcs_b1", got_bytes[18], 8'h39);
            chk("fcs_b2", got_bytes[19], 8'hF4);
            chk("fcs_b3", got_bytes[20], 8'hCB);
`endif
        end

        // Randomized frames with occasional starvation and req drops after grant.
        begin_scn(b0, b1);
        drop_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            who = $urandom_range(0, 1);
            len = $urandom_range(1, 8);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'($urandom);
            push(who, len, ab, v);
        end
        run_and_check("rand", b0, b1);
        drop_en = 1'b0;

        // Reset during the 4th preamble cycle, then contend after release.
        begin_scn(b0, b1);
        push(0, 3, -1, 128'h030201);
        repeat (5) @(negedge clk);
        chk("prerst_valid", phy_tx_valid, 1'b1);
        chk("prerst_gnt0", s0_gnt, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", phy_tx_valid, 1'b0);
        chk("async_data", phy_tx_data, 8'h00);
        chk("async_gnt0", s0_gnt, 1'b0);
        chk("async_ack0", s0_ack, 1'b0);
        chk("async_done_underrun", {frame_done, underrun}, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_prio = 0;
        begin_scn(b0, b1);
        push(1, 2, -1, 128'hBBAA);
        push(0, 2, -1, 128'hDDCC);
        run_and_check("post_rst", b0, b1);
        chk("post_rst_first_owner", (got_owner.size() > 0) ? got_owner[0] : -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
